// File: rtl/exc_commit_ctrl_pkg.sv
// rtl/exc_commit_ctrl_pkg.sv - CP0 register numbers, ExcCodes and commit FSM state type
package exc_commit_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;

    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_EXL_MASK  = 32'h0000_0002;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_BADV,
        S_W_STATUS,
        S_REDIR
    } state_t;

    // Only address-error exceptions carry a faulting address into BadVAddr.
    function automatic logic needs_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// rtl/exc_commit_ctrl_if.sv - WB commit request, CP0 port and redirect bundle
interface exc_commit_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              ws_req_valid;
    logic              ws_ex;
    logic [4:0]        ws_excode;
    logic              ws_bd;
    logic [DATA_W-1:0] ws_pc;
    logic [DATA_W-1:0] ws_badvaddr;
    logic              ws_eret;
    logic              ws_mtc0;
    logic [4:0]        ws_mtc0_addr;
    logic [DATA_W-1:0] ws_mtc0_data;
    logic              int_req;
    logic [DATA_W-1:0] cp0_status;
    logic [DATA_W-1:0] cp0_cause;
    logic [DATA_W-1:0] cp0_epc;
    logic              ws_ready;
    logic              cp0_we;
    logic [4:0]        cp0_waddr;
    logic [DATA_W-1:0] cp0_wdata;
    logic              flush;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        output ws_req_valid, ws_ex, ws_excode, ws_bd, ws_pc, ws_badvaddr,
        output ws_eret, ws_mtc0, ws_mtc0_addr, ws_mtc0_data,
        output int_req, cp0_status, cp0_cause, cp0_epc,
        input  ws_ready, cp0_we, cp0_waddr, cp0_wdata,
        input  flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  ws_req_valid, ws_ex, ws_excode, ws_bd, ws_pc, ws_badvaddr,
        input  ws_eret, ws_mtc0, ws_mtc0_addr, ws_mtc0_data,
        input  int_req, cp0_status, cp0_cause, cp0_epc,
        output ws_ready, cp0_we, cp0_waddr, cp0_wdata,
        output flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_cp0_wmux.sv
// rtl/exc_cp0_wmux.sv - selects the single CP0 write (we/waddr/wdata) from FSM state and latched context
module exc_cp0_wmux
    import exc_commit_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  state_t            state,
    input  logic              mtc0_fire,
    input  logic [4:0]        mtc0_addr,
    input  logic [DATA_W-1:0] mtc0_data,
    input  logic [DATA_W-1:0] lat_pc,
    input  logic              lat_bd,
    input  logic [4:0]        lat_excode,
    input  logic [DATA_W-1:0] lat_badvaddr,
    input  logic              lat_exl_set,
    input  logic              lat_is_eret,
    input  logic [DATA_W-1:0] cp0_cause,
    input  logic [DATA_W-1:0] cp0_status,
    output logic              we,
    output logic [4:0]        waddr,
    output logic [DATA_W-1:0] wdata
);
    always_comb begin
        we    = 1'b0;
        waddr = 5'd0;
        wdata = '0;
        case (state)
            S_IDLE: begin
                if (mtc0_fire) begin
                    we    = 1'b1;
                    waddr = mtc0_addr;
                    wdata = mtc0_data;
                end
            end
            S_W_EPC: begin
                // A nested exception under EXL must keep the original return address.
                we    = !lat_exl_set;
                waddr = CP0_EPC;
                wdata = lat_bd ? (lat_pc - DATA_W'(4)) : lat_pc;
            end
            S_W_CAUSE: begin
                we    = 1'b1;
                waddr = CP0_CAUSE;
                wdata = {lat_bd, cp0_cause[DATA_W-2:7], lat_excode, cp0_cause[1:0]};
            end
            S_W_BADV: begin
                we    = 1'b1;
                waddr = CP0_BADVADDR;
                wdata = lat_badvaddr;
            end
            S_W_STATUS: begin
                we    = 1'b1;
                waddr = CP0_STATUS;
                wdata = lat_is_eret ? (cp0_status & ~DATA_W'(STATUS_EXL_MASK))
                                    : (cp0_status |  DATA_W'(STATUS_EXL_MASK));
            end
            default: begin
                we    = 1'b0;
                waddr = 5'd0;
                wdata = '0;
            end
        endcase
    end
endmodule

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - WB commit sequencer owning the CP0 write port for exceptions, interrupts, ERET and MTC0
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEFAULT,
    parameter int          DATA_W   = 32
) (
    input  logic               clk,
    input  logic               resetn,
    exc_commit_ctrl_if.slave   bus
);
    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] lat_pc;
    logic              lat_bd;
    logic [4:0]        lat_excode;
    logic [DATA_W-1:0] lat_badvaddr;
    logic [DATA_W-1:0] lat_target;
    logic              lat_need_badv;
    logic              lat_exl_set;
    logic              lat_is_eret;

    logic              accept_exc;
    logic              accept_eret;
    logic              mtc0_fire;
    logic [4:0]        excode_in;

    // Priority ex > int > eret > mtc0; MTC0 is also held off while reset is asserted.
    assign accept_exc  = bus.ws_req_valid && (bus.ws_ex || bus.int_req);
    assign accept_eret = bus.ws_req_valid && !bus.ws_ex && !bus.int_req && bus.ws_eret;
    assign mtc0_fire   = resetn && bus.ws_req_valid && !bus.ws_ex && !bus.int_req
                         && !bus.ws_eret && bus.ws_mtc0;
    assign excode_in   = bus.ws_ex ? bus.ws_excode : EXC_INT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_pc        <= '0;
            lat_bd        <= 1'b0;
            lat_excode    <= 5'd0;
            lat_badvaddr  <= '0;
            lat_target    <= '0;
            lat_need_badv <= 1'b0;
            lat_exl_set   <= 1'b0;
            lat_is_eret   <= 1'b0;
        end else if (state == S_IDLE) begin
            if (accept_exc) begin
                lat_pc        <= bus.ws_pc;
                lat_bd        <= bus.ws_bd;
                lat_excode    <= excode_in;
                lat_badvaddr  <= bus.ws_badvaddr;
                lat_need_badv <= needs_badvaddr(excode_in);
                lat_exl_set   <= bus.cp0_status[1];
                lat_is_eret   <= 1'b0;
            end else if (accept_eret) begin
                lat_target    <= bus.cp0_epc;
                lat_is_eret   <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_exc) begin
                    state_nxt = S_W_EPC;
                end else if (accept_eret) begin
                    state_nxt = S_W_STATUS;
                end
            end
            S_W_EPC:    state_nxt = S_W_CAUSE;
            S_W_CAUSE:  state_nxt = lat_need_badv ? S_W_BADV : S_W_STATUS;
            S_W_BADV:   state_nxt = S_W_STATUS;
            S_W_STATUS: state_nxt = S_REDIR;
            S_REDIR:    state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ws_ready       = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (state)
            S_IDLE: begin
                bus.ws_ready = !(accept_exc || accept_eret);
            end
            S_REDIR: begin
                bus.ws_ready       = 1'b1;
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = lat_is_eret ? lat_target : DATA_W'(EX_ENTRY);
            end
            default: begin
                bus.ws_ready = 1'b0;
            end
        endcase
    end

    exc_cp0_wmux #(
        .DATA_W (DATA_W)
    ) u_wmux (
        .state        (state),
        .mtc0_fire    (mtc0_fire),
        .mtc0_addr    (bus.ws_mtc0_addr),
        .mtc0_data    (bus.ws_mtc0_data),
        .lat_pc       (lat_pc),
        .lat_bd       (lat_bd),
        .lat_excode   (lat_excode),
        .lat_badvaddr (lat_badvaddr),
        .lat_exl_set  (lat_exl_set),
        .lat_is_eret  (lat_is_eret),
        .cp0_cause    (bus.cp0_cause),
        .cp0_status   (bus.cp0_status),
        .we           (bus.cp0_we),
        .waddr        (bus.cp0_waddr),
        .wdata        (bus.cp0_wdata)
    );
endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
Sequencer that owns the single CP0 write port and commits exceptions, interrupts, ERET and MTC0 from the write-back stage. It stalls WB while it performs the multi-register CP0 update (EPC, Cause, BadVAddr, Status) one write per cycle. It then issues a one-cycle pipeline flush and front-end redirect. It sits between wb_stage and the CP0 register file.

Parameters:
EX_ENTRY, 32'hBFC00380, exception vector driven on redirect_pc
DATA_W, 32, width of CP0 data and PC

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous reset, active-low
ws_req_valid  in  1  WB holds a valid committing instruction
ws_ex  in  1  WB instruction carries a synchronous exception
ws_excode  in  5  ExcCode of that exception
ws_bd  in  1  instruction is in a branch delay slot
ws_pc  in  32  PC of WB instruction
ws_badvaddr  in  32  faulting address (AdEL/AdES)
ws_eret  in  1  WB instruction is ERET
ws_mtc0  in  1  WB instruction is MTC0
ws_mtc0_addr  in  5  MTC0 target register number
ws_mtc0_data  in  32  MTC0 write data
int_req  in  1  CP0 reports an enabled, unmasked pending interrupt
cp0_status  in  32  current Status
cp0_cause  in  32  current Cause
cp0_epc  in  32  current EPC
ws_ready  out  1  WB ready_go; WB retires its instruction only when 1
cp0_we  out  1  CP0 write enable
cp0_waddr  out  5  CP0 write register number
cp0_wdata  out  32  CP0 write data
flush  out  1  one-cycle flush of all stages IF..WB
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  32  redirect target

Behaviour:
- Reset (async, resetn=0): state IDLE; latched pc/bd/excode/badvaddr/target cleared; cp0_we=0, flush=0, redirect_valid=0, redirect_pc=0. Reset mid-sequence aborts with no further CP0 writes.
- States: IDLE, W_EPC, W_CAUSE, W_BADV, W_STATUS, REDIR.
- IDLE priority when ws_req_valid=1:
  - ws_ex or int_req: ws_ready=0, cp0_we=0. Latch pc, bd, badvaddr, excode (int_req without ws_ex gives excode 0), need_badv = excode is 4 or 5, exl_set = cp0_status[1]. Go to W_EPC.
  - ws_eret: ws_ready=0. Latch target=cp0_epc. Go to W_STATUS.
  - ws_mtc0: cp0_we=1, waddr=ws_mtc0_addr, wdata=ws_mtc0_data in the same cycle, ws_ready=1. Stay in IDLE.
  - Otherwise: ws_ready=1, cp0_we=0.
- Priority order is ex > int > eret > mtc0. An interrupt never takes an ERET or MTC0 cycle.
- ws_req_valid=0 in IDLE: ws_ready=1, no action.
- W_EPC: waddr=14, wdata = bd ? pc-4 : pc (32-bit wrap). cp0_we = !exl_set, so EPC is not overwritten when EXL is already set. Next state W_CAUSE.
- W_CAUSE: waddr=13, wdata = {bd, cp0_cause[30:7], excode, cp0_cause[1:0]}. Next state W_BADV if need_badv, else W_STATUS.
- W_BADV: waddr=8, wdata=latched badvaddr. Next state W_STATUS.
- W_STATUS: waddr=12. Exception path: wdata = cp0_status | 32'h2. ERET path: wdata = cp0_status & ~32'h2. Next state REDIR.
- REDIR: flush=1, redirect_valid=1, redirect_pc = EX_ENTRY (exception) or target (ERET), ws_ready=1, cp0_we=0. Next state IDLE.
- ws_ready=0 in all non-IDLE states except REDIR.
- WS inputs are ignored outside IDLE; latched values are used even if ws_req_valid drops.
- Latency from the IDLE accept cycle: exception redirect at cycle +4 (+5 with BadVAddr); ERET redirect at cycle +2.
- Back-to-back: the first IDLE cycle after REDIR may accept a new request.
- Exactly one CP0 write per cycle, never two.

Decomposition:
- Shared package holds CP0 register numbers (BADVADDR=8, STATUS=12, CAUSE=13, EPC=14), ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8), the state enum, and EX_ENTRY default.
- One natural sub-module: exc_cp0_wmux, a combinational waddr/wdata/we selector from state plus latched context. FSM and latches stay in the top.

Test Plan:
- Syscall, excode 8, pc=0xBFC00100, bd=0, EXL=0 -> writes EPC=0xBFC00100, Cause[6:2]=8, Status|=2 on consecutive cycles; flush/redirect to 0xBFC00380 at cycle +4; ws_ready low cycles +0..+3.
- AdEL in delay slot, pc=0xBFC00204, badvaddr=0x00000003 -> EPC=0xBFC00200, Cause[31]=1, BadVAddr=3, Status write; redirect at cycle +5.
- ERET with cp0_epc=0xBFC00300 -> single Status write clearing bit 1; redirect_pc=0xBFC00300 at cycle +2.
- MTC0 to reg 11, data 0x1234 -> cp0_we same cycle, ws_ready=1, no flush. Same MTC0 with int_req=1 -> interrupt sequence runs, excode 0, no write to reg 11.
- Exception while Status.EXL=1 -> no EPC write (cp0_we=0 in W_EPC), Cause and Status still written, redirect occurs.
- resetn low during W_CAUSE -> outputs zero immediately; after release, ws_ready=1 and no further CP0 writes.
